alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of the shared combinational ALU. It accepts operations from two independent requesters over valid/ready handshakes and issues one operation at a time to the ALU. It captures the 64-bit result and the four status flags into registers and returns them on a single tagged response channel. It owns the ALU's control and operand inputs; nothing else drives the ALU.

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared combinational ALU.
// One operation in flight at a time; the result and flags come back on a tagged response channel.
module alu_arbiter #(
    parameter int REGISTER_LENGTH    = 64,
    parameter int ALU_CONTROL_LENGTH = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic                          req0_valid_i,
    output logic                          req0_ready_o,
    input  logic [ALU_CONTROL_LENGTH-1:0] req0_op_i,
    input  logic [REGISTER_LENGTH-1:0]    req0_a_i,
    input  logic [REGISTER_LENGTH-1:0]    req0_b_i,

    input  logic                          req1_valid_i,
    output logic                          req1_ready_o,
    input  logic [ALU_CONTROL_LENGTH-1:0] req1_op_i,
    input  logic [REGISTER_LENGTH-1:0]    req1_a_i,
    input  logic [REGISTER_LENGTH-1:0]    req1_b_i,

    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_id_o,
    output logic [REGISTER_LENGTH-1:0]    rsp_result_o,
    output logic                          rsp_zero_o,
    output logic                          rsp_overflow_o,
    output logic                          rsp_carryout_o,
    output logic                          rsp_negative_o,
    output logic                          rsp_error_o,

    output logic [ALU_CONTROL_LENGTH-1:0] alu_control_o,
    output logic [REGISTER_LENGTH-1:0]    alu_a_o,
    output logic [REGISTER_LENGTH-1:0]    alu_b_o,
    input  logic [REGISTER_LENGTH-1:0]    alu_result_i,
    input  logic                          alu_zero_i,
    input  logic                          alu_overflow_i,
    input  logic                          alu_carryout_i,
    input  logic                          alu_negative_i
);

    localparam logic [ALU_CONTROL_LENGTH-1:0] OP_PASS_B   = ALU_CONTROL_LENGTH'(0);
    localparam logic [ALU_CONTROL_LENGTH-1:0] OP_ADD      = ALU_CONTROL_LENGTH'(2);
    localparam logic [ALU_CONTROL_LENGTH-1:0] OP_SUBTRACT = ALU_CONTROL_LENGTH'(3);
    localparam logic [ALU_CONTROL_LENGTH-1:0] OP_AND      = ALU_CONTROL_LENGTH'(4);
    localparam logic [ALU_CONTROL_LENGTH-1:0] OP_OR       = ALU_CONTROL_LENGTH'(5);
    localparam logic [ALU_CONTROL_LENGTH-1:0] OP_XOR      = ALU_CONTROL_LENGTH'(6);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic                          last_grant;
    logic [ALU_CONTROL_LENGTH-1:0] op_q;
    logic [REGISTER_LENGTH-1:0]    a_q;
    logic [REGISTER_LENGTH-1:0]    b_q;

    logic                          any_valid;
    logic                          winner;
    logic                          accept;
    logic                          illegal_op;

    // Ready is gated by reset so nothing can be accepted while reset is held.
    always_comb begin
        any_valid    = req0_valid_i || req1_valid_i;
        winner       = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
        accept       = (state == IDLE) && any_valid && !reset_i;
        req0_ready_o = accept && !winner;
        req1_ready_o = accept && winner;
    end

    always_comb begin
        illegal_op = 1'b1;
        case (op_q)
            OP_PASS_B, OP_ADD, OP_SUBTRACT, OP_AND, OP_OR, OP_XOR: illegal_op = 1'b0;
            default:                                               illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // last_grant starts at 1 so requester 0 wins the first contention.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
        end else if (accept) begin
            last_grant <= winner;
            op_q       <= winner ? req1_op_i : req0_op_i;
            a_q        <= winner ? req1_a_i  : req0_a_i;
            b_q        <= winner ? req1_b_i  : req0_b_i;
        end
    end

    // last_grant still names the requester of the operation being executed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_id_o       <= 1'b0;
            rsp_result_o   <= '0;
            rsp_zero_o     <= 1'b0;
            rsp_overflow_o <= 1'b0;
            rsp_carryout_o <= 1'b0;
            rsp_negative_o <= 1'b0;
            rsp_error_o    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id_o <= last_grant;
            if (illegal_op) begin
                rsp_result_o   <= '0;
                rsp_zero_o     <= 1'b0;
                rsp_overflow_o <= 1'b0;
                rsp_carryout_o <= 1'b0;
                rsp_negative_o <= 1'b0;
                rsp_error_o    <= 1'b1;
            end else begin
                rsp_result_o   <= alu_result_i;
                rsp_zero_o     <= alu_zero_i;
                rsp_overflow_o <= alu_overflow_i;
                rsp_carryout_o <= alu_carryout_i;
                rsp_negative_o <= alu_negative_i;
                rsp_error_o    <= 1'b0;
            end
        end
    end

    assign rsp_valid_o   = (state == RESP);
    assign alu_control_o = op_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU sits on the ALU port and a cycle-level
// reference model predicts grants, response timing and response contents.
module tb_alu_arbiter;

    logic        clk_i;
    logic        reset_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [2:0]  req0_op_i, req1_op_i;
    logic [63:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
    logic [63:0] rsp_result_o;
    logic        rsp_zero_o, rsp_overflow_o, rsp_carryout_o, rsp_negative_o, rsp_error_o;
    logic [2:0]  alu_control_o;
    logic [63:0] alu_a_o, alu_b_o, alu_result_i;
    logic        alu_zero_i, alu_overflow_i, alu_carryout_i, alu_negative_i;

    typedef struct packed {
        logic [63:0] result;
        logic        z;
        logic        o;
        logic        c;
        logic        n;
    } alu_out_t;

    typedef struct {
        logic        id;
        logic [63:0] result;
        logic        z;
        logic        o;
        logic        c;
        logic        n;
        logic        err;
    } rsp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   stage = 0;
    logic model_last = 1'b1;
    rsp_t sb[$];
    logic id_log[$];
    bit   log_en = 0;
    int   rsp_mode = 2;

    alu_out_t env_alu;

    alu_arbiter #(.REGISTER_LENGTH(64), .ALU_CONTROL_LENGTH(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_overflow_o(rsp_overflow_o),
        .rsp_carryout_o(rsp_carryout_o), .rsp_negative_o(rsp_negative_o), .rsp_error_o(rsp_error_o),
        .alu_control_o(alu_control_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_overflow_i(alu_overflow_i),
        .alu_carryout_i(alu_carryout_i), .alu_negative_i(alu_negative_i)
    );

    // Illegal opcodes deliberately produce non-zero garbage so suppression is observable.
    function automatic alu_out_t alu_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        alu_out_t   r;
        logic [64:0] wide;
        r = '0;
        case (op)
            3'd0: r.result = b;
            3'd2: begin
                wide     = {1'b0, a} + {1'b0, b};
                r.result = wide[63:0];
                r.c      = wide[64];
                r.o      = (a[63] == b[63]) && (r.result[63] != a[63]);
            end
            3'd3: begin
                wide     = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r.result = wide[63:0];
                r.c      = wide[64];
                r.o      = (a[63] != b[63]) && (r.result[63] != a[63]);
            end
            3'd4: r.result = a & b;
            3'd5: r.result = a | b;
            3'd6: r.result = a ^ b;
            default: begin
                r.result = a ^ b ^ 64'hDEAD_BEEF_0000_0001;
                r.c = 1'b1;
                r.o = 1'b1;
                r.z = 1'b1;
                r.n = 1'b1;
                return r;
            end
        endcase
        r.z = (r.result == 64'd0);
        r.n = r.result[63];
        return r;
    endfunction

    function automatic rsp_t expect_rsp(input logic id, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        rsp_t     e;
        alu_out_t m;
        e.id = id;
        if (op == 3'd1 || op == 3'd7) begin
            e.result = 64'd0; e.z = 0; e.o = 0; e.c = 0; e.n = 0; e.err = 1;
        end else begin
            m = alu_model(op, a, b);
            e.result = m.result; e.z = m.z; e.o = m.o; e.c = m.c; e.n = m.n; e.err = 0;
        end
        return e;
    endfunction

    always_comb env_alu = alu_model(alu_control_o, alu_a_o, alu_b_o);
    assign alu_result_i   = env_alu.result;
    assign alu_zero_i     = env_alu.z;
    assign alu_overflow_i = env_alu.o;
    assign alu_carryout_i = env_alu.c;
    assign alu_negative_i = env_alu.n;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: predicts grants and response timing at each falling edge, then advances the model.
    always @(negedge clk_i) begin
        logic any, win;
        rsp_t e;
        if (reset_i) begin
            checkOutput("reset req0_ready", req0_ready_o, 0);
            checkOutput("reset req1_ready", req1_ready_o, 0);
            checkOutput("reset rsp_valid", rsp_valid_o, 0);
            checkOutput("reset rsp_id", rsp_id_o, 0);
            checkOutput("reset rsp_result", rsp_result_o, 0);
            checkOutput("reset rsp_flags", {rsp_zero_o, rsp_overflow_o, rsp_carryout_o, rsp_negative_o}, 0);
            checkOutput("reset rsp_error", rsp_error_o, 0);
            checkOutput("reset alu_control", alu_control_o, 0);
            checkOutput("reset alu_a", alu_a_o, 0);
            checkOutput("reset alu_b", alu_b_o, 0);
            stage = 0;
            model_last = 1'b1;
            sb.delete();
        end else begin
            any = req0_valid_i || req1_valid_i;
            win = (req0_valid_i && req1_valid_i) ? ~model_last : req1_valid_i;
            checkOutput("req0_ready", req0_ready_o, (stage == 0 && any && !win) ? 1 : 0);
            checkOutput("req1_ready", req1_ready_o, (stage == 0 && any && win) ? 1 : 0);
            checkOutput("rsp_valid", rsp_valid_o, (stage == 2) ? 1 : 0);
            if (stage == 2) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL scoreboard: response expected but queue empty at %0t", $time);
                end else begin
                    checkOutput("rsp_id", rsp_id_o, sb[0].id);
                    checkOutput("rsp_result", rsp_result_o, sb[0].result);
                    checkOutput("rsp_zero", rsp_zero_o, sb[0].z);
                    checkOutput("rsp_overflow", rsp_overflow_o, sb[0].o);
                    checkOutput("rsp_carryout", rsp_carryout_o, sb[0].c);
                    checkOutput("rsp_negative", rsp_negative_o, sb[0].n);
                    checkOutput("rsp_error", rsp_error_o, sb[0].err);
                end
            end
            case (stage)
                0: if (any) begin
                    e = win ? expect_rsp(1'b1, req1_op_i, req1_a_i, req1_b_i)
                            : expect_rsp(1'b0, req0_op_i, req0_a_i, req0_b_i);
                    sb.push_back(e);
                    model_last = win;
                    stage = 1;
                end
                1: stage = 2;
                default: if (rsp_ready_i) begin
                    if (sb.size() > 0) begin
                        if (log_en) id_log.push_back(sb[0].id);
                        void'(sb.pop_front());
                    end
                    stage = 0;
                end
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rsp_mode == 0) rsp_ready_i = 1'b1;
            else if (rsp_mode == 1) rsp_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Presents one operation on a requester and holds it until accepted; returns 1 ns after the accept edge.
    task automatic applyStimulus(input int which, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        bit got = 0;
        if (which == 0) begin
            req0_op_i = op; req0_a_i = a; req0_b_i = b; req0_valid_i = 1'b1;
        end else begin
            req1_op_i = op; req1_a_i = a; req1_b_i = b; req1_valid_i = 1'b1;
        end
        while (!got && n < 200) begin
            @(negedge clk_i);
            got = (which == 0) ? req0_ready_o : req1_ready_o;
            n++;
        end
        @(posedge clk_i);
        #1;
        if (which == 0) req0_valid_i = 1'b0;
        else            req1_valid_i = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept timeout: requester %0d never granted", which);
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        do begin
            @(negedge clk_i);
            #1;
            n++;
        end while ((stage != 0 || sb.size() != 0) && n < 300);
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain timeout: stage=%0d pending=%0d", stage, sb.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 0; rsp_ready_i = 0;
        req0_valid_i = 0; req1_valid_i = 0;
        req0_op_i = 0; req0_a_i = 0; req0_b_i = 0;
        req1_op_i = 0; req1_a_i = 0; req1_b_i = 0;
        #1 reset_i = 1'b1;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        rsp_mode = 0;
        @(posedge clk_i); #1;

        $display("[TB] reset during EXEC");
        applyStimulus(0, 3'd2, 64'd5, 64'd7);
        reset_i = 1'b1;
        #2;
        checkOutput("midexec alu_control", alu_control_o, 0);
        checkOutput("midexec alu_a", alu_a_o, 0);
        checkOutput("midexec alu_b", alu_b_o, 0);
        checkOutput("midexec rsp_valid", rsp_valid_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("post-reset no response", rsp_valid_o, 0);

        $display("[TB] single request");
        applyStimulus(0, 3'd2, 64'h5, 64'h7);
        waitDrain();

        $display("[TB] contention");
        doReset();
        log_en = 1; id_log.delete();
        fork
            applyStimulus(0, 3'd3, 64'd3, 64'd3);
            applyStimulus(1, 3'd6, 64'hFF, 64'hFF);
        join
        waitDrain();
        log_en = 0;
        checkOutput("contention count", 64'(id_log.size()), 2);
        for (int i = 0; i < 2 && i < id_log.size(); i++)
            checkOutput($sformatf("contention id[%0d]", i), id_log[i], 64'(i));

        $display("[TB] round-robin fairness");
        doReset();
        log_en = 1; id_log.delete();
        fork
            for (int i = 0; i < 3; i++) applyStimulus(0, 3'd2, 64'(i), 64'd1);
            for (int j = 0; j < 3; j++) applyStimulus(1, 3'd5, 64'(j), 64'h10);
        join
        waitDrain();
        log_en = 0;
        checkOutput("fairness count", 64'(id_log.size()), 6);
        for (int i = 0; i < 6 && i < id_log.size(); i++)
            checkOutput($sformatf("fairness id[%0d]", i), id_log[i], 64'(i % 2));

        $display("[TB] overflow and negative");
        applyStimulus(1, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        waitDrain();

        $display("[TB] illegal opcode under backpressure");
        rsp_mode = 2;
        rsp_ready_i = 1'b0;
        applyStimulus(0, 3'd7, 64'h1234, 64'h00FF);
        fork
            applyStimulus(1, 3'd2, 64'd1, 64'd2);
        join_none
        repeat (5) @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        rsp_mode = 0;
        wait fork;
        waitDrain();

        $display("[TB] randomized traffic");
        rsp_mode = 1;
        fork
            for (int i = 0; i < 15; i++) begin
                int g;
                g = $urandom_range(0, 3);
                if (g > 0) begin repeat (g) @(posedge clk_i); #1; end
                applyStimulus(0, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                              ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom});
            end
            for (int j = 0; j < 15; j++) begin
                int g;
                g = $urandom_range(0, 3);
                if (g > 0) begin repeat (g) @(posedge clk_i); #1; end
                applyStimulus(1, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
            end
        join
        rsp_mode = 0;
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
